pipe_div_arb: RTL

PIPE_DIV_ARB -- requirements
Module: pipe_div_arb

---
 rtl/pipe_div_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipe_div_arb.sv
// Round-robin front end sharing one fixed-latency pipelined divider among NUM_REQ requesters.
// A tag pipeline tracks issued divisions and routes each result back to its requester.
module pipe_div_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEND_W  = 32,
  parameter int unsigned SOR_W   = 32,
  parameter int unsigned LAT     = DEND_W,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DEND_W-1:0]   req_dividend_i,
  input  logic [NUM_REQ*SOR_W-1:0]    req_divisor_i,
  output logic                        div_valid_o,
  output logic [DEND_W-1:0]           div_dividend_o,
  output logic [SOR_W-1:0]            div_divisor_o,
  input  logic                        div_valid_i,
  input  logic [DEND_W-1:0]           div_quotient_i,
  input  logic [SOR_W-1:0]            div_remainder_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DEND_W-1:0]           rsp_quotient_o,
  output logic [SOR_W-1:0]            rsp_remainder_o,
  output logic                        rsp_dz_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]  MaxOut = 4'(MAX_OUT);

  logic [3:0]         cnt_q [NUM_REQ];
  logic [3:0]         cnt_d [NUM_REQ];
  logic [IdW-1:0]     last_q;
  logic [IdW-1:0]     grant_id;
  logic               grant_vld;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;

  logic               div_valid_q;
  logic [DEND_W-1:0]  div_dend_q;
  logic [SOR_W-1:0]   div_sor_q;
  logic [IdW-1:0]     iss_id_q;
  logic               iss_dz_q;

  logic [LAT-1:0]     tag_v_q;
  logic [LAT-1:0]     tag_dz_q;
  logic [IdW-1:0]     tag_id_q [LAT];

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DEND_W-1:0]  rsp_quot_q;
  logic [SOR_W-1:0]   rsp_rem_q;
  logic               rsp_dz_q;
  logic               err_q;

  logic               em_v;
  logic               em_dz;
  logic [IdW-1:0]     em_id;
  logic               em_match;
  logic               em_mismatch;
  logic [SOR_W-1:0]   grant_sor;

  // Ready is held low during reset so nothing is accepted on the reset edge.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = rst_n && req_valid_i[i] && (cnt_q[i] < MaxOut);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!grant_vld && elig[(32'(last_q) + off) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_id  = IdW'((32'(last_q) + off) % NUM_REQ);
      end
    end
    grant = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
  end

  assign grant_sor = req_divisor_i[32'(grant_id) * SOR_W +: SOR_W];

  assign em_v        = tag_v_q[LAT-1];
  assign em_dz       = tag_dz_q[LAT-1];
  assign em_id       = tag_id_q[LAT-1];
  assign em_match    = em_v && div_valid_i;
  assign em_mismatch = em_v ^ div_valid_i;

  // Simultaneous grant and response leave the count unchanged.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !rsp_valid_q[i]) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (!grant[i] && rsp_valid_q[i] && (cnt_q[i] != 4'd0)) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_comb begin
    busy_o = |tag_v_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cnt_q[i] != 4'd0) busy_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= IdW'(NUM_REQ - 1);
      div_valid_q <= 1'b0;
      div_dend_q  <= '0;
      div_sor_q   <= '0;
      iss_id_q    <= '0;
      iss_dz_q    <= 1'b0;
      tag_v_q     <= '0;
      tag_dz_q    <= '0;
      rsp_valid_q <= '0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_dz_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned k = 0; k < LAT; k++) tag_id_q[k] <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= 4'd0;
    end else begin
      div_valid_q <= grant_vld;
      if (grant_vld) begin
        last_q     <= grant_id;
        div_dend_q <= req_dividend_i[32'(grant_id) * DEND_W +: DEND_W];
        div_sor_q  <= grant_sor;
        iss_id_q   <= grant_id;
        iss_dz_q   <= (grant_sor == '0);
      end
      // Tag enters one cycle after issue so it leaves with the divider result.
      for (int unsigned k = LAT - 1; k > 0; k--) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_dz_q[k] <= tag_dz_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
      tag_v_q[0]  <= div_valid_q;
      tag_dz_q[0] <= iss_dz_q;
      tag_id_q[0] <= iss_id_q;
      rsp_valid_q <= em_match ? (NUM_REQ'(1) << em_id) : '0;
      if (em_match) begin
        rsp_quot_q <= div_quotient_i;
        rsp_rem_q  <= div_remainder_i;
        rsp_dz_q   <= em_dz;
      end
      err_q <= err_q | em_mismatch;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign req_ready_o     = grant;
  assign div_valid_o     = div_valid_q;
  assign div_dividend_o  = div_dend_q;
  assign div_divisor_o   = div_sor_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_quotient_o  = rsp_quot_q;
  assign rsp_remainder_o = rsp_rem_q;
  assign rsp_dz_o        = rsp_dz_q;
  assign err_o           = err_q;

endmodule
